// File: rtl/cbrt_seq_param.sv
// ---------------------------------------------------------------------------
// cbrt_seq_param
//   Sequential integer cube root y = floor(cbrt(x)) for a W-bit unsigned x.
//   The result is built by binary search from the MSB down. Each trial
//   candidate is cubed by one shift-add datapath that is used twice: first
//   for cand*cand, then for sq*cand. Each pass handles one multiplier bit
//   per cycle.
//   Cycles per result bit: 2R+1. Total latency: R*(2R+1)+1.
//
//   Optional feature macro: CBRT_REM_EN. When it is defined, the rem_bo port
//   is added and carries the remainder x - y^3.
//
// Ports
//   clk_i    in   1  clock, rising edge
//   rst_ni   in   1  asynchronous active-low reset
//   start_i  in   1  request, sampled only while idle (level-sensitive)
//   x_bi     in   W  operand, latched when start is accepted
//   y_bo     out  R  result, valid with done_o, held until the next done_o
//   busy_o   out  1  high while a computation is in progress
//   done_o   out  1  one-cycle pulse, result valid
//   rem_bo   out  W  x - y^3 (only with CBRT_REM_EN)
// ---------------------------------------------------------------------------
module cbrt_seq_param #(
  parameter  int W = 8,
  localparam int R = (W + 2) / 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] x_bi,
  output logic [R-1:0] y_bo,
  output logic         busy_o,
  output logic         done_o
`ifdef CBRT_REM_EN
  ,
  output logic [W-1:0] rem_bo
`endif
);

  localparam int PW = 3 * R;
  localparam int BW = (R > 1) ? $clog2(R) : 1;
  localparam logic [BW-1:0] R_LAST     = BW'(R - 1);
  localparam logic [PW-1:0] FIRST_CAND = PW'(1) << (R - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_CUBE = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [R-1:0]   acc_q, acc_d;
  logic [BW-1:0]  b_q, b_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [R-1:0]   y_q, y_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef CBRT_REM_EN
  logic [PW-1:0]  cube_q, cube_d;
  logic [W-1:0]   rem_q, rem_d;
`endif

  logic [R-1:0]   cand_s;
  logic [PW-1:0]  addend_s;
  logic [PW-1:0]  prod_sum_s;
  logic           fits_s;
  logic [R-1:0]   next_acc_s;
  logic [R-1:0]   next_cand_s;

  // The multiplier is the candidate in both passes. The multiplicand
  // register is shifted left once per cycle, so no barrel shifter is needed.
  assign cand_s      = acc_q | (R'(1) << b_q);
  assign addend_s    = cand_s[cnt_q] ? mcand_q : {PW{1'b0}};
  assign prod_sum_s  = prod_q + addend_s;
  // The full 3R-bit cube is compared, so overflowing candidates are rejected.
  assign fits_s      = (prod_q <= PW'(x_q));
  assign next_acc_s  = fits_s ? cand_s : acc_q;
  assign next_cand_s = next_acc_s | (R'(1) << (b_q - BW'(1)));

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef CBRT_REM_EN
    cube_d  = cube_q;
    rem_d   = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_bi;
          acc_d   = {R{1'b0}};
          b_d     = R_LAST;
          cnt_d   = {BW{1'b0}};
          mcand_d = FIRST_CAND;
          prod_d  = {PW{1'b0}};
          busy_d  = 1'b1;
`ifdef CBRT_REM_EN
          cube_d  = {PW{1'b0}};
`endif
          state_d = S_SQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SQ: begin
        prod_d  = prod_sum_s;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + BW'(1);
        if (cnt_q == R_LAST) begin
          // The square becomes the multiplicand for the cube pass.
          mcand_d = prod_sum_s;
          prod_d  = {PW{1'b0}};
          cnt_d   = {BW{1'b0}};
          state_d = S_CUBE;
        end else begin
          state_d = S_SQ;
        end
      end
      S_CUBE: begin
        prod_d  = prod_sum_s;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + BW'(1);
        if (cnt_q == R_LAST) begin
          cnt_d   = {BW{1'b0}};
          state_d = S_CMP;
        end else begin
          state_d = S_CUBE;
        end
      end
      S_CMP: begin
        acc_d = next_acc_s;
`ifdef CBRT_REM_EN
        if (fits_s) begin
          cube_d = prod_q;
        end else begin
          cube_d = cube_q;
        end
`endif
        if (b_q == {BW{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          b_d     = b_q - BW'(1);
          mcand_d = PW'(next_cand_s);
          prod_d  = {PW{1'b0}};
          state_d = S_SQ;
        end
      end
      S_DONE: begin
        y_d     = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef CBRT_REM_EN
        rem_d   = W'(PW'(x_q) - cube_q);
`endif
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything and aborts any
  // operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      x_q     <= {W{1'b0}};
      acc_q   <= {R{1'b0}};
      b_q     <= {BW{1'b0}};
      cnt_q   <= {BW{1'b0}};
      mcand_q <= {PW{1'b0}};
      prod_q  <= {PW{1'b0}};
      y_q     <= {R{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CBRT_REM_EN
      cube_q  <= {PW{1'b0}};
      rem_q   <= {W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CBRT_REM_EN
      cube_q  <= cube_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign y_bo   = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
`ifdef CBRT_REM_EN
  assign rem_bo = rem_q;
`endif

endmodule
